// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register-file write arbiter
// Purpose: width constants, arbiter state encoding and register-file default values.
// Ports: none (package).
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Values the register file reloads while rf_reset is held.
  localparam logic [RF_DATA_W-1:0] X1_RESET  = 32'd1;
  localparam logic [RF_DATA_W-1:0] X29_RESET = 32'd252;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant
// Purpose: grants one of two requesters; on a tie the one not granted last wins.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   en             grants allowed this cycle
//   req0, req1     requests
//   update         a grant was taken this cycle; remember who won
//   gnt0, gnt1     one-hot-or-zero grant, purely combinational from inputs and rr_last
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt0,
  output logic gnt1
);

  // rr_last: 0 = ch0 granted last, 1 = ch1 granted last. Resets to 1 so ch0 wins the first tie.
  logic rr_last_q, rr_last_d;

  always_comb begin
    gnt0      = en & req0 & (~req1 | rr_last_q);
    gnt1      = en & req1 & (~req0 | ~rr_last_q);
    rr_last_d = rr_last_q;
    if (update) rr_last_d = gnt1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register-file write port
// Purpose: holds the register file in reset for INIT_CYCLES edges after reset release,
//   then shares the single write port between ch0 (ALU) and ch1 (load) with valid/ready.
//   Writes to x0 are accepted but suppressed and flagged on x0_drop.
// Optional: REGFILE_WRITE_ARBITER_BYPASS_EN adds write-to-read forwarding on two read ports.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   reqN_valid/addr/data/ready      requester channel N (N = 0, 1)
//   rf_reset                        register-file synchronous reset
//   rf_wr_en/addr/data              register-file write port (registered)
//   init_done                       high in RUN
//   x0_drop                         one-cycle pulse after an accepted x0 write
//   rd_addrN, rf_rdataN, rd_dataN   bypass read ports (only with the macro)
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_reset,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              init_done,
  output logic              x0_drop
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
`endif
);

  localparam logic [3:0] INIT_CNT = 4'(INIT_CYCLES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              drop_q, drop_d;

  logic              gnt0, gnt1, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == RUN),
    .req0   (req0_valid),
    .req1   (req1_valid),
    .update (xfer),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  always_comb begin
    req0_ready = gnt0;
    req1_ready = gnt1;
    xfer       = gnt0 | gnt1;
    sel_addr   = gnt1 ? req1_addr : req0_addr;
    sel_data   = gnt1 ? req1_data : req0_data;

    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    drop_d    = 1'b0;

    if (state_q == INIT) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) state_d = RUN;
    end

    if (xfer) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
      wr_en_d   = (sel_addr != '0);
      drop_d    = (sel_addr == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= INIT;
      cnt_q     <= INIT_CNT;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      drop_q    <= drop_d;
    end
  end

  assign rf_reset   = (state_q == INIT);
  assign init_done  = (state_q == RUN);
  assign rf_wr_en   = wr_en_q;
  assign rf_wr_addr = wr_addr_q;
  assign rf_wr_data = wr_data_q;
  assign x0_drop    = drop_q;

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
  // The register file's read data is captured on the same edge that commits the write,
  // so it shows the old value. Capture that committed write alongside the read address
  // and substitute its data when they match.
  logic              byp_en_q, byp_en_d;
  logic [ADDR_W-1:0] byp_addr_q, byp_addr_d;
  logic [DATA_W-1:0] byp_data_q, byp_data_d;
  logic [ADDR_W-1:0] rd_addr1_q, rd_addr1_d;
  logic [ADDR_W-1:0] rd_addr2_q, rd_addr2_d;

  always_comb begin
    byp_en_d   = wr_en_q;
    byp_addr_d = wr_addr_q;
    byp_data_d = wr_data_q;
    rd_addr1_d = rd_addr1;
    rd_addr2_d = rd_addr2;
    rd_data1   = rf_rdata1;
    rd_data2   = rf_rdata2;
    if (byp_en_q && (rd_addr1_q != '0) && (rd_addr1_q == byp_addr_q)) rd_data1 = byp_data_q;
    if (byp_en_q && (rd_addr2_q != '0) && (rd_addr2_q == byp_addr_q)) rd_data2 = byp_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byp_en_q   <= 1'b0;
      byp_addr_q <= '0;
      byp_data_q <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
    end else begin
      byp_en_q   <= byp_en_d;
      byp_addr_q <= byp_addr_d;
      byp_data_q <= byp_data_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_reset, rf_wr_en, init_done, x0_drop;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  regfile_write_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_reset   (rf_reset),
    .rf_wr_en   (rf_wr_en),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .init_done  (init_done),
    .x0_drop    (x0_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        drop;
  } wr_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  exp_q[$];
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                              input logic r0, input logic r1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  // Called at a negedge: drive one cycle, check readies, then check the registered write.
  task automatic apply(input vec_t v, input string name);
    wr_t e, got;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    #1;
    chk({name, " req0_ready"}, 32'(req0_ready), 32'(v.r0));
    chk({name, " req1_ready"}, 32'(req1_ready), 32'(v.r1));
    e.en = 1'b0; e.drop = 1'b0; e.addr = last_addr; e.data = last_data;
    if (v.r0) begin
      e.addr = v.a0; e.data = v.d0;
    end else if (v.r1) begin
      e.addr = v.a1; e.data = v.d1;
    end
    if (v.r0 || v.r1) begin
      e.en   = (e.addr != 5'd0);
      e.drop = (e.addr == 5'd0);
    end
    last_addr = e.addr;
    last_data = e.data;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk({name, " rf_wr_en"},   32'(rf_wr_en),   32'(got.en));
      chk({name, " rf_wr_addr"}, 32'(rf_wr_addr), 32'(got.addr));
      chk({name, " rf_wr_data"}, rf_wr_data,      got.data);
      chk({name, " x0_drop"},    32'(x0_drop),    32'(got.drop));
    end
  endtask

  // Called at a negedge with reset high; releases reset and walks the INIT window.
  task automatic init_seq(input string name);
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h2;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, " rf_reset edge1"},  32'(rf_reset),   32'd1);
    chk({name, " init_done edge1"}, 32'(init_done),  32'd0);
    chk({name, " req0_ready init"}, 32'(req0_ready), 32'd0);
    chk({name, " req1_ready init"}, 32'(req1_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({name, " rf_wr_en init"},   32'(rf_wr_en),   32'd0);
    @(negedge clk);
    chk({name, " rf_reset edge2"},  32'(rf_reset),   32'd0);
    chk({name, " init_done edge2"}, 32'(init_done),  32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    last_addr  = 5'd0;
    last_data  = 32'd0;
  endtask

  initial begin
    vecs[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,      1, 0);
    vecs[1]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      0, 0);
    vecs[2]  = mk(0, 5'd0,  32'h0,        1, 5'd9, 32'h99,     0, 1);
    vecs[3]  = mk(1, 5'd3,  32'h3333,     1, 5'd7, 32'h7777,   1, 0);
    vecs[4]  = mk(1, 5'd3,  32'h3333,     1, 5'd7, 32'h7777,   0, 1);
    vecs[5]  = mk(1, 5'd3,  32'h3333,     1, 5'd7, 32'h7777,   1, 0);
    vecs[6]  = mk(1, 5'd3,  32'h3333,     1, 5'd7, 32'h7777,   0, 1);
    vecs[7]  = mk(0, 5'd0,  32'h0,        1, 5'd0, 32'h55,     0, 1);
    vecs[8]  = mk(0, 5'd0,  32'h0,        0, 5'd0, 32'h0,      0, 0);
    vecs[9]  = mk(1, 5'd31, 32'hFFFFFFFF, 1, 5'd1, 32'h1,      1, 0);
    vecs[10] = mk(1, 5'd2,  32'h2,        1, 5'd1, 32'h1,      0, 1);
    vecs[11] = mk(1, 5'd0,  32'hAA,       0, 5'd0, 32'h0,      1, 0);

    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h2;
    last_addr = 5'd0;
    last_data = 32'd0;
    @(negedge clk);
    chk("reset rf_reset",   32'(rf_reset),   32'd1);
    chk("reset rf_wr_en",   32'(rf_wr_en),   32'd0);
    chk("reset rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("reset rf_wr_data", rf_wr_data,      32'd0);
    chk("reset init_done",  32'(init_done),  32'd0);
    chk("reset x0_drop",    32'(x0_drop),    32'd0);
    chk("reset req0_ready", 32'(req0_ready), 32'd0);
    chk("reset req1_ready", 32'(req1_ready), 32'd0);

    init_seq("init1");

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Mid-operation reset while a write is on the port.
    apply(mk(1, 5'd4, 32'h4444, 0, 5'd0, 32'h0, 1, 0), "pre_reset");
    chk("pre_reset wr_en high", 32'(rf_wr_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async rf_wr_en",   32'(rf_wr_en),   32'd0);
    chk("async rf_reset",   32'(rf_reset),   32'd1);
    chk("async init_done",  32'(init_done),  32'd0);
    chk("async rf_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("async rf_wr_data", rf_wr_data,      32'd0);
    @(negedge clk);
    init_seq("init2");

    // rr pointer must be back at its reset value: ch0 wins the first tie.
    apply(mk(1, 5'd12, 32'hC0C0, 1, 5'd13, 32'hD0D0, 1, 0), "post_reset_tie");
    apply(mk(0, 5'd0,  32'h0,    1, 5'd13, 32'hD0D0, 0, 1), "post_reset_ch1");
    apply(mk(0, 5'd0,  32'h0,    0, 5'd0,  32'h0,    0, 0), "post_reset_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
